// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and timing helper for the UART receiver
package uart_pkg;

  // Payload width of one 8N1 frame.
  localparam int DATA_BITS = 8;

  // Receiver frame-tracking states.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_rx_state_t;

  // Whole clocks per serial bit; the fractional part is dropped.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for a single asynchronous bit
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops give the first one a full cycle to resolve metastability.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 UART receiver sampling each bit at its midpoint
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 100_000_000,
  parameter int BAUD_RATE    = 9600,
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE)
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       rx_i,
  output logic       valid_o,
  output logic [7:0] byte_o
);

  // Counter must hold CLKS_PER_BIT-1; keep at least one bit for tiny ratios.
  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_IDX  = 3'(DATA_BITS - 1);

  logic rx_s;

  uart_rx_state_t state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] byte_q, byte_d;
  logic                 valid_q, valid_d;

  // Line idles high, so the synchroniser is preset to 1 to avoid a false start after reset.
  sync_2ff #(
    .RESET_VALUE(1'b1)
  ) u_sync_rx (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .d_i    (rx_i),
    .q_o    (rx_s)
  );

  // State, baud counter, shift register and output registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
    end
  end

  // Frame tracking: a half-bit wait centres all later samples in their bit cells.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = HALF_LOAD;
        end
      end

      START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!rx_s) begin
          state_d = DATA;
          idx_d   = '0;
          cnt_d   = FULL_LOAD;
        end else begin
          // Line was high again at mid-start: treat the dip as noise.
          state_d = IDLE;
        end
      end

      DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d[idx_q] = rx_s;
          cnt_d          = FULL_LOAD;
          if (idx_q == LAST_IDX) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

      STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rx_s) begin
          // Leaving at mid-stop keeps half a bit of slack to catch an immediate next start.
          byte_d  = shift_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end else begin
          // Framing error or break: drop the byte and wait for the line to recover.
          state_d = WAIT_IDLE;
        end
      end

      WAIT_IDLE: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign valid_o = valid_q;
  assign byte_o  = byte_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - randomized self-checking bench for uart_rx_core
module tb_uart_rx_core;

  localparam int CLK_HZ = 100_000_000;
  localparam int BAUD   = 3_125_000;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int LAT_NOM = (19 * CPB) / 2 + 3;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       rx_i;
  logic       valid_o;
  logic [7:0] byte_o;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  logic [7:0] exp_q[$];
  logic [7:0] last_good;
  int         pulses = 0;
  bit         prev_valid = 1'b0;
  int         fall_cycle = 0;
  bit         measure_lat = 1'b0;

  uart_rx_core #(
    .CLK_FREQ_HZ(CLK_HZ),
    .BAUD_RATE  (BAUD)
  ) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .rx_i   (rx_i),
    .valid_o(valid_o),
    .byte_o (byte_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cycle <= cycle + 1;

  // Scoreboard: every valid pulse must match the oldest frame sent with a good stop bit.
  always @(negedge clk_i) begin
    logic [7:0] e;
    int lat;
    if (valid_o === 1'b1) begin
      pulses++;
      checks++;
      if (prev_valid) begin
        failures++;
        $display("FAIL valid_width: valid_o high on consecutive cycles, required single-cycle pulse");
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid: byte_o=%02h, required no pulse", byte_o);
      end else begin
        e = exp_q.pop_front();
        last_good = e;
        if (byte_o !== e) begin
          failures++;
          $display("FAIL byte_value: byte_o=%02h required=%02h", byte_o, e);
        end
      end
      if (measure_lat) begin
        lat = cycle - fall_cycle;
        checks++;
        if (lat < LAT_NOM - 2 || lat > LAT_NOM + 2) begin
          failures++;
          $display("FAIL latency: got=%0d clocks required=%0d+-2", lat, LAT_NOM);
        end
      end
    end
    prev_valid = (valid_o === 1'b1);
  end

  task automatic idle_cycles(input int n);
    rx_i = 1'b1;
    repeat (n) @(negedge clk_i);
  endtask

  // Drives one full frame; caller must be sitting on a negedge.
  task automatic send_frame(input logic [7:0] b, input bit stop_bit);
    if (stop_bit) exp_q.push_back(b);
    rx_i = 1'b0;
    fall_cycle = cycle;
    repeat (CPB) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (CPB) @(negedge clk_i);
    end
    rx_i = stop_bit;
    repeat (CPB) @(negedge clk_i);
  endtask

  task automatic check_drained(input string name, input int pulses_before, input int expected_new);
    checks++;
    if (pulses - pulses_before !== expected_new || exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_count: pulses=%0d pending=%0d required pulses=%0d pending=0",
               name, pulses - pulses_before, exp_q.size(), expected_new);
      exp_q.delete();
    end
    checks++;
    if (byte_o !== last_good) begin
      failures++;
      $display("FAIL %s_hold: byte_o=%02h required=%02h", name, byte_o, last_good);
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    rx_i    = 1'b1;
    last_good = 8'h00;
    #10;
    reset_i = 1'b0;
    for (int i = 0; i < CPB; i++) begin
      @(negedge clk_i);
      checks++;
      if (valid_o !== 1'b0 || byte_o !== 8'h00) begin
        failures++;
        $display("FAIL reset_state: valid_o=%b byte_o=%02h required valid_o=0 byte_o=00", valid_o, byte_o);
      end
    end
  endtask

  task automatic test_back_to_back();
    int p0 = pulses;
    for (int v = 0; v < 15; v++) send_frame(8'(v), 1'b1);
    idle_cycles(CPB);
    check_drained("back_to_back", p0, 15);
  endtask

  task automatic test_pair_latency();
    int p0 = pulses;
    measure_lat = 1'b1;
    send_frame(8'hA5, 1'b1);
    send_frame(8'h5A, 1'b1);
    measure_lat = 1'b0;
    idle_cycles(CPB);
    check_drained("pair", p0, 2);
  endtask

  task automatic test_glitch();
    int p0 = pulses;
    rx_i = 1'b0;
    repeat (3) @(negedge clk_i);
    idle_cycles(2 * CPB);
    check_drained("glitch", p0, 0);
    p0 = pulses;
    send_frame(8'h3C, 1'b1);
    idle_cycles(CPB);
    check_drained("after_glitch", p0, 1);
  endtask

  task automatic test_break();
    int p0 = pulses;
    send_frame(8'hFF, 1'b0);
    repeat (3 * CPB) @(negedge clk_i);
    idle_cycles(CPB);
    check_drained("break", p0, 0);
    p0 = pulses;
    send_frame(8'h81, 1'b1);
    idle_cycles(CPB);
    check_drained("after_break", p0, 1);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b = 8'h99;
    int p0 = pulses;
    rx_i = 1'b0;
    repeat (CPB) @(negedge clk_i);
    for (int i = 0; i < 4; i++) begin
      rx_i = b[i];
      repeat (CPB) @(negedge clk_i);
    end
    rx_i = b[4];
    repeat (CPB / 2) @(negedge clk_i);
    reset_i = 1'b1;
    #1;
    checks++;
    if (valid_o !== 1'b0 || byte_o !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid: valid_o=%b byte_o=%02h required valid_o=0 byte_o=00", valid_o, byte_o);
    end
    last_good = 8'h00;
    @(negedge clk_i);
    reset_i = 1'b0;
    idle_cycles(CPB);
    check_drained("reset_mid", p0, 0);
    p0 = pulses;
    send_frame(8'h42, 1'b1);
    idle_cycles(CPB);
    check_drained("after_reset_mid", p0, 1);
  endtask

  task automatic test_random();
    int p0 = pulses;
    int good = 0;
    for (int n = 0; n < 12; n++) begin
      logic [7:0] b = 8'($urandom);
      bit ok = ($urandom_range(0, 4) != 0);
      if (ok) good++;
      send_frame(b, ok);
      // A bad stop bit needs the line back high for a while before the next start.
      idle_cycles(ok ? $urandom_range(0, 2 * CPB) : CPB + $urandom_range(0, CPB));
    end
    idle_cycles(CPB);
    check_drained("random", p0, good);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_pair_latency();
    test_glitch();
    test_break();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
